// File: rtl/sram16_bridge.sv
// sram16_bridge: 32-bit bus slave in front of an asynchronous 16-bit SRAM.
// Each bus access becomes one or two halfword phases (LO then HI). Each phase lasts
// WAIT_CYCLES+1 cycles and is followed by a one-cycle ack and a settle cycle.
// All outputs are registered. They are computed from the next state, so the strobes
// line up with the state they belong to.
// Optional build macro: SRAM16_BRIDGE_TURNAROUND_EN inserts an idle bus cycle
// between LO and HI, and after SETTLE when the access was a write.
module sram16_bridge #(
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   sel_i,
    input  logic [31:0]            addr_i,
    input  logic                   we_i,
    input  logic [3:0]             wr_mask_i,
    input  logic [31:0]            data_in_i,
    output logic [31:0]            data_out_o,
    output logic                   ack_o,
    output logic [SRAM_ADDR_W-1:0] sram_addr_o,
    output logic [15:0]            sram_dq_o,
    input  logic [15:0]            sram_dq_i,
    output logic                   sram_dq_oe_o,
    output logic                   sram_ce_n_o,
    output logic                   sram_oe_n_o,
    output logic                   sram_we_n_o,
    output logic                   sram_lb_n_o,
    output logic                   sram_ub_n_o
);

    localparam int unsigned CntW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES);
    localparam bit          ZeroWait = (WAIT_CYCLES == 0);

    typedef enum logic [2:0] {
        StIdle, StLo, StHi, StAck, StSettle, StGapLh, StGapWr
    } state_t;

    state_t                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [SRAM_ADDR_W-2:0] addr_q, addr_d;
    logic                   we_q, we_d;
    logic [3:0]             mask_q, mask_d;
    logic [31:0]            wdata_q, wdata_d;

    logic [31:0]            data_out_q, data_out_d;
    logic                   ack_q, ack_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]            sram_dq_q, sram_dq_d;
    logic                   dq_oe_q, dq_oe_d;
    logic                   ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                   lb_n_q, lb_n_d, ub_n_q, ub_n_d;

    logic                   last_q;
    logic                   hi_d;
    logic                   unused_addr;

    assign unused_addr = ^{addr_i[31:SRAM_ADDR_W+1], addr_i[1:0]};
    assign last_q      = (cnt_q == CntMax);

    // State, counter, request latch and registered outputs
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            mask_q      <= '0;
            wdata_q     <= '0;
            data_out_q  <= '0;
            ack_q       <= 1'b0;
            sram_addr_q <= '0;
            sram_dq_q   <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            data_out_q  <= data_out_d;
            ack_q       <= ack_d;
            sram_addr_q <= sram_addr_d;
            sram_dq_q   <= sram_dq_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
        end
    end

    // Capture the request only on acceptance; later bus changes are ignored
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        if (state_q == StIdle && sel_i) begin
            addr_d  = addr_i[SRAM_ADDR_W:2];
            we_d    = we_i;
            mask_d  = wr_mask_i;
            wdata_d = data_in_i;
        end
    end

    // Next-state and phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (sel_i) begin
                    cnt_d = '0;
                    if (we_i && wr_mask_i == 4'b0000)     state_d = StAck;
                    else if (we_i && wr_mask_i[1:0] == 2'b00) state_d = StHi;
                    else                                  state_d = StLo;
                end
            end
            StLo: begin
                if (last_q) begin
                    cnt_d = '0;
                    if (we_q && mask_q[3:2] == 2'b00) state_d = StAck;
`ifdef SRAM16_BRIDGE_TURNAROUND_EN
                    else                              state_d = StGapLh;
`else
                    else                              state_d = StHi;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHi: begin
                if (last_q) begin
                    cnt_d   = '0;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAck:    state_d = StSettle;
`ifdef SRAM16_BRIDGE_TURNAROUND_EN
            StSettle: state_d = we_q ? StGapWr : StIdle;
`else
            StSettle: state_d = StIdle;
`endif
            StGapLh:  state_d = StHi;
            StGapWr:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output next-values derived from the upcoming state; read data captured on last phase cycle
    always_comb begin
        ack_d       = (state_d == StAck);
        data_out_d  = data_out_q;
        sram_addr_d = sram_addr_q;
        sram_dq_d   = '0;
        dq_oe_d     = 1'b0;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        lb_n_d      = 1'b1;
        ub_n_d      = 1'b1;
        hi_d        = (state_d == StHi);

        if (state_d == StLo || state_d == StHi) begin
            ce_n_d      = 1'b0;
            sram_addr_d = {addr_d, hi_d};
            if (we_d) begin
                dq_oe_d   = 1'b1;
                sram_dq_d = hi_d ? wdata_d[31:16] : wdata_d[15:0];
                lb_n_d    = hi_d ? ~mask_d[2] : ~mask_d[0];
                ub_n_d    = hi_d ? ~mask_d[3] : ~mask_d[1];
                // Release we_n on the final phase cycle so data/address hold past the edge
                we_n_d    = ~(ZeroWait || (cnt_d != CntMax));
            end else begin
                oe_n_d = 1'b0;
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
        end

        if (!we_q && last_q) begin
            if (state_q == StLo)      data_out_d[15:0]  = sram_dq_i;
            else if (state_q == StHi) data_out_d[31:16] = sram_dq_i;
        end
    end

    assign data_out_o   = data_out_q;
    assign ack_o        = ack_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_dq_o    = sram_dq_q;
    assign sram_dq_oe_o = dq_oe_q;
    assign sram_ce_n_o  = ce_n_q;
    assign sram_oe_n_o  = oe_n_q;
    assign sram_we_n_o  = we_n_q;
    assign sram_lb_n_o  = lb_n_q;
    assign sram_ub_n_o  = ub_n_q;

endmodule
